matrix_mem_responder: RTL and testbench

MATRIX_MEM_RESPONDER -- requirements
Module: matrix_mem_responder

---
 rtl/matrix_mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 22 ++
 rtl/matrix_mem_responder.sv | 101 ++++++++++
 tb/tb_matrix_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_mem_pkg.sv
// Shared constants, FSM encoding and address helpers for matrix_mem_responder.
package matrix_mem_pkg;

    localparam int DEF_W       = 32;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_LATENCY = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned depth);
        return (addr < base) || (word_offset(addr, base) >= depth) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x W, registered read. Contents are never reset.
module mem_array #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/matrix_mem_responder.sv
// Fixed-latency memory responder: one transaction at a time, done pulse LATENCY cycles after start.
// Optional MEM_ERR_CHECK_EN flags out-of-range / misaligned accesses instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start, captures the request
// BUSY  | latency countdown (skipped when LATENCY == 1)
// DONE  | done pulse; write commits on the way out
module matrix_mem_responder
    import matrix_mem_pkg::*;
#(
    parameter int          W         = DEF_W,
    parameter int          DEPTH     = DEF_DEPTH,
    parameter int          LATENCY   = DEF_LATENCY,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_memory_transaction,
    input  logic [31:0]  address_in,
    input  logic         write_en,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         done_memory_transaction,
    output logic         access_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_in;
    logic             wr_q;
    logic             err_q;
    logic             err_in;
    logic [W-1:0]     wdata_q;
    logic             mem_we;
    logic             mem_re;
    logic [IDX_W-1:0] mem_addr;
    logic [W-1:0]     mem_rdata;

`ifdef MEM_ERR_CHECK_EN
    assign err_in = addr_err(address_in, BASE_ADDR, DEPTH);
`else
    assign err_in = 1'b0;
`endif

    assign idx_in = IDX_W'(word_offset(address_in, BASE_ADDR));

    // Read lands in the RAM output register on the edge that enters DONE; with
    // LATENCY == 1 that edge is the start edge itself, so the live address is used.
    assign mem_re = !rst && (
        (state == ST_IDLE && LATENCY == 1 && start_memory_transaction && !write_en && !err_in) ||
        (state == ST_BUSY && cnt == 4'd1 && !wr_q && !err_q));
    assign mem_we   = !rst && state == ST_DONE && wr_q && !err_q;
    assign mem_addr = (state == ST_IDLE) ? idx_in : idx_q;

    mem_array #(.W(W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_memory_transaction) begin
                        idx_q   <= idx_in;
                        wr_q    <= write_en;
                        err_q   <= err_in;
                        wdata_q <= data_in;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done_memory_transaction = (state == ST_DONE);
    assign access_err              = (state == ST_DONE) && err_q;
    assign data_out = (state == ST_DONE && !wr_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Bench for matrix_mem_responder: behavioural model + per-cycle compare, directed and random traffic.
module tb_matrix_mem_responder;

    localparam int          W     = 32;
    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0;

    logic         clk = 1'b0;
    logic         rst, start, we, done, aerr;
    logic [31:0]  addr;
    logic [W-1:0] din, dout;
    logic         rst1, start1, we1, done1, aerr1;
    logic [31:0]  addr1;
    logic [W-1:0] din1, dout1;

    always #5 clk = ~clk;

    matrix_mem_responder #(.W(W), .DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start_memory_transaction(start), .address_in(addr),
        .write_en(we), .data_in(din), .data_out(dout),
        .done_memory_transaction(done), .access_err(aerr));

    matrix_mem_responder #(.W(W), .DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .rst(rst1), .start_memory_transaction(start1), .address_in(addr1),
        .write_en(we1), .data_in(din1), .data_out(dout1),
        .done_memory_transaction(done1), .access_err(aerr1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    logic [W-1:0] mem_m [DEPTH];
    bit           busy_m = 0;
    int           done_at = 0;
    bit           p_wr, p_err;
    int           p_idx;
    logic [W-1:0] p_wd;
    logic         exp_done, exp_err;
    logic [W-1:0] exp_data;

    // observations
    int           done_count = 0;
    int           last_done_cyc = 0;
    int           last_start_cyc = 0;
    logic [W-1:0] last_rd = '0;
    logic         last_err = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
`ifdef MEM_ERR_CHECK_EN
        return (a < BASE) || ((a - BASE) >= 32'(DEPTH * 4)) || (a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(((a - BASE) / 4) % 32'(DEPTH));
    endfunction

    task automatic step(input bit r, input bit s, input logic [31:0] a, input bit w,
                        input logic [W-1:0] d);
        rst = r; start = s; addr = a; we = w; din = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            busy_m = 0;
        end else if (busy_m && cyc == done_at + 1) begin
            if (p_wr && !p_err) mem_m[p_idx] = p_wd;
            busy_m = 0;
        end else if (!busy_m && s) begin
            busy_m = 1;
            done_at = cyc + LAT - 1;
            p_wr = w; p_err = is_err(a); p_idx = idx_of(a); p_wd = d;
            last_start_cyc = cyc;
        end
        exp_done = busy_m && cyc == done_at;
        exp_err  = exp_done && p_err;
        exp_data = (exp_done && !p_wr && !p_err) ? mem_m[p_idx] : '0;
        #1;
        chk("done", W'(done), W'(exp_done));
        chk("data_out", dout, exp_data);
        chk("access_err", W'(aerr), W'(exp_err));
        if (done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
            last_rd = dout;
            last_err = aerr;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, '0);
    endtask

    // start plus enough idle cycles that the next start is the first accepted one
    task automatic txn(input bit w, input logic [31:0] a, input logic [W-1:0] d);
        step(0, 1, a, w, d);
        idle(LAT);
    endtask

    initial begin
        rst1 = 1'b1; start1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;

        step(1, 0, 32'h0, 0, '0);
        step(1, 1, 32'h4, 1, 32'hFFFF_FFFF);
        chk("reset_done", W'(done), '0);
        idle(2);

        for (int i = 0; i < DEPTH; i++) txn(1, 32'(i * 4), 32'hA500_0000 + 32'(i));

        txn(1, 32'h08, 32'h0000_1234);
        txn(0, 32'h08, '0);
        chk("rd_0x08", last_rd, 32'h0000_1234);
        chk("latency", W'(last_done_cyc - last_start_cyc), W'(LAT - 1));

        for (int i = 0; i < 18; i++) txn(1, 32'(i * 4), 32'hC0DE_0000 | 32'(i));
        for (int i = 0; i < 18; i++) begin
            txn(0, 32'(i * 4), '0);
            chk("rd18", last_rd, 32'hC0DE_0000 | 32'(i));
        end

        done_count = 0;
        step(0, 1, 32'h20, 1, 32'h5555_AAAA);
        step(0, 1, 32'h30, 0, '0);
        idle(4);
        chk("busy_start_ignored", W'(done_count), W'(1));

        done_count = 0;
        step(0, 1, 32'h10, 1, 32'hDEAD_BEEF);
        step(1, 0, 32'h0, 0, '0);
        idle(3);
        chk("reset_no_done", W'(done_count), W'(0));
        txn(0, 32'h10, '0);
        chk("reset_no_commit", last_rd, 32'hC0DE_0004);

`ifdef MEM_ERR_CHECK_EN
        txn(0, 32'h102, '0);
        chk("err_flag", W'(last_err), W'(1));
        chk("err_data", last_rd, '0);
`else
        txn(0, 32'h100, '0);
        chk("wrap_word0", last_rd, 32'hC0DE_0000);
        chk("no_err", W'(last_err), W'(0));
`endif

        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 2))
                0:       a = 32'($urandom_range(0, DEPTH - 1) * 4);
                1:       a = 32'($urandom_range(0, 255) * 4);
                default: a = 32'($urandom_range(0, 1023));
            endcase
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, a,
                 $urandom_range(0, 1) == 1, W'($urandom));
        end
        idle(4);

        // LATENCY=1 instance: done one cycle after start, next start two cycles after
        rst1 = 1'b0; start1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; din1 = 32'h0000_ABCD;
        @(posedge clk); #1;
        chk("l1_done_t1", W'(done1), W'(1));
        chk("l1_wr_data0", dout1, '0);
        start1 = 1'b1; we1 = 1'b0;
        @(posedge clk); #1;
        chk("l1_done_low", W'(done1), W'(0));
        start1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
        @(posedge clk); #1;
        chk("l1_accept_t2", W'(done1), W'(1));
        chk("l1_rd", dout1, 32'h0000_ABCD);
        chk("l1_err", W'(aerr1), W'(0));
        start1 = 1'b0;
        @(posedge clk); #1;
        chk("l1_idle_data", dout1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
